// File: rtl/wb_pkg.sv
// Shared constants for the MEM/WB write-back stage: load types, source selects, default widths.
package wb_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned NSRC_DEF       = 4;

  localparam logic [2:0] LT_WORD = 3'd0;
  localparam logic [2:0] LT_LB   = 3'd1;
  localparam logic [2:0] LT_LBU  = 3'd2;
  localparam logic [2:0] LT_LH   = 3'd3;
  localparam logic [2:0] LT_LHU  = 3'd4;

  localparam int unsigned WB_SRC_ALU  = 0;
  localparam int unsigned WB_SRC_MEM  = 1;
  localparam int unsigned WB_SRC_LINK = 2;
  localparam int unsigned WB_SRC_HILO = 3;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-side bundle into the W stage and the W-stage / forwarding outputs.
interface writeback_stage_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NSRC       = 4
);
  localparam int unsigned SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic                   StallW;
  logic                   FlushW;
  logic                   ValidM;
  logic                   RegWriteM;
  logic [REG_ADDR_W-1:0]  WriteRegM;
  logic [SEL_W-1:0]       WbSelM;
  logic [NSRC*DATA_W-1:0] SrcDataM;
  logic [2:0]             LoadTypeM;
  logic [1:0]             ByteOffM;

  logic                   ValidW;
  logic                   RegWriteW;
  logic [REG_ADDR_W-1:0]  WriteRegW;
  logic [DATA_W-1:0]      WriteDataW;
  logic                   FwdValid;
  logic [REG_ADDR_W-1:0]  FwdReg;
  logic [DATA_W-1:0]      FwdData;
  logic [31:0]            RetireCount;

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, WriteRegM, WbSelM, SrcDataM, LoadTypeM, ByteOffM,
    input  ValidW, RegWriteW, WriteRegW, WriteDataW, FwdValid, FwdReg, FwdData, RetireCount
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, WriteRegM, WbSelM, SrcDataM, LoadTypeM, ByteOffM,
    output ValidW, RegWriteW, WriteRegW, WriteDataW, FwdValid, FwdReg, FwdData, RetireCount
  );
endinterface

// File: rtl/wb_load_extract.sv
// Sub-word load extraction: picks a little-endian byte/halfword lane and sign/zero-extends it.
module wb_load_extract
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        load_type_i,
  input  logic [1:0]        byte_off_i,
  output logic [DATA_W-1:0] data_o
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = data_i[{byte_off_i, 3'b000} +: 8];
    // Halfword lane uses only the upper offset bit; a misaligned offset is silently rounded down.
    half_lane = data_i[{byte_off_i[1], 4'b0000} +: 16];
    case (load_type_i)
      LT_LB:   data_o = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      LT_LBU:  data_o = {{(DATA_W-8){1'b0}}, byte_lane};
      LT_LH:   data_o = {{(DATA_W-16){half_lane[15]}}, half_lane};
      LT_LHU:  data_o = {{(DATA_W-16){1'b0}}, half_lane};
      default: data_o = data_i;
    endcase
  end
endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with write-back source select, forwarding copy and retire counter.
// Define WB_LOAD_EXT_EN to enable sub-word load extraction on the memory source.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned NSRC       = NSRC_DEF
) (
  input logic             Clk,
  input logic             Reset,
  writeback_stage_if.slave bus
);
  localparam int unsigned SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic                  valid_q, valid_d;
  logic                  regwr_q, regwr_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  fvalid_q, fvalid_d;
  logic [REG_ADDR_W-1:0] freg_q, freg_d;
  logic [DATA_W-1:0]     fdata_q, fdata_d;
  logic [31:0]           retire_q, retire_d;

  logic [DATA_W-1:0]     src_sel;
  logic [DATA_W-1:0]     wb_data;

  // Out-of-range selects fall back to source 0.
  always_comb begin
    src_sel = bus.SrcDataM[0 +: DATA_W];
    for (int unsigned k = 1; k < NSRC; k++) begin
      if (bus.WbSelM == SEL_W'(k)) src_sel = bus.SrcDataM[k*DATA_W +: DATA_W];
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [DATA_W-1:0] mem_ext;

  wb_load_extract #(
    .DATA_W(DATA_W)
  ) u_load_extract (
    .data_i     (bus.SrcDataM[WB_SRC_MEM*DATA_W +: DATA_W]),
    .load_type_i(bus.LoadTypeM),
    .byte_off_i (bus.ByteOffM),
    .data_o     (mem_ext)
  );

  assign wb_data = (bus.WbSelM == SEL_W'(WB_SRC_MEM)) ? mem_ext : src_sel;
`else
  logic unused_load_info;
  assign unused_load_info = ^{bus.LoadTypeM, bus.ByteOffM};
  assign wb_data = src_sel;
`endif

  always_comb begin
    valid_d  = valid_q;
    regwr_d  = regwr_q;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    fvalid_d = fvalid_q;
    freg_d   = freg_q;
    fdata_d  = fdata_q;
    retire_d = retire_q;
    // Flush overrides stall, so a flush edge is never a hold edge.
    if (bus.FlushW || !bus.StallW) begin
      fvalid_d = regwr_q;
      freg_d   = wreg_q;
      fdata_d  = wdata_q;
    end
    if (bus.FlushW) begin
      valid_d = 1'b0;
      regwr_d = 1'b0;
      wreg_d  = '0;
      wdata_d = '0;
    end else if (!bus.StallW) begin
      valid_d  = bus.ValidM;
      regwr_d  = bus.RegWriteM & bus.ValidM & (bus.WriteRegM != '0);
      wreg_d   = bus.WriteRegM;
      wdata_d  = wb_data;
      retire_d = retire_q + {31'b0, bus.ValidM};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q  <= 1'b0;
      regwr_q  <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      fvalid_q <= 1'b0;
      freg_q   <= '0;
      fdata_q  <= '0;
      retire_q <= '0;
    end else begin
      valid_q  <= valid_d;
      regwr_q  <= regwr_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      fvalid_q <= fvalid_d;
      freg_q   <= freg_d;
      fdata_q  <= fdata_d;
      retire_q <= retire_d;
    end
  end

  assign bus.ValidW      = valid_q;
  assign bus.RegWriteW   = regwr_q;
  assign bus.WriteRegW   = wreg_q;
  assign bus.WriteDataW  = wdata_q;
  assign bus.FwdValid    = fvalid_q;
  assign bus.FwdReg      = freg_q;
  assign bus.FwdData     = fdata_q;
  assign bus.RetireCount = retire_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage, plus stall/flush/reset/wrap sequences.
module tb_writeback_stage;
  import wb_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  writeback_stage_if #(.DATA_W(32), .REG_ADDR_W(5), .NSRC(4)) bus ();

  writeback_stage #(
    .DATA_W    (32),
    .REG_ADDR_W(5),
    .NSRC      (4)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] s0;
    logic [2:0]  lt;
    logic [1:0]  off;
    logic        erw;
    logic [31:0] ext;
    logic [31:0] raw;
  } vec_t;

  localparam logic [31:0] MemWord  = 32'h80FF_7F01;
  localparam logic [31:0] LinkWord = 32'h0040_0008;
  localparam logic [31:0] HiloWord = 32'hCAFE_F00D;

  int n_err = 0;
  int n_chk = 0;
  vec_t vecs[13];

  function automatic vec_t mk(logic v, logic rw, logic [4:0] rd, logic [1:0] sel,
                              logic [31:0] s0, logic [2:0] lt, logic [1:0] off, logic erw,
                              logic [31:0] ext, logic [31:0] raw);
    vec_t r;
    r.v = v; r.rw = rw; r.rd = rd; r.sel = sel; r.s0 = s0; r.lt = lt; r.off = off;
    r.erw = erw; r.ext = ext; r.raw = raw;
    return r;
  endfunction

  function automatic logic [31:0] exp_data(vec_t x);
`ifdef WB_LOAD_EXT_EN
    return x.ext;
`else
    return x.raw;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic rw, logic [4:0] rd, logic [1:0] sel, logic [31:0] s0,
                       logic [2:0] lt, logic [1:0] off);
    bus.ValidM    = v;
    bus.RegWriteM = rw;
    bus.WriteRegM = rd;
    bus.WbSelM    = sel;
    bus.SrcDataM  = {HiloWord, LinkWord, MemWord, s0};
    bus.LoadTypeM = lt;
    bus.ByteOffM  = off;
  endtask

  task automatic chk_w(string tag, logic v, logic rw, logic [4:0] rd, logic [31:0] d);
    chk({tag, ".ValidW"}, 32'(bus.ValidW), 32'(v));
    chk({tag, ".RegWriteW"}, 32'(bus.RegWriteW), 32'(rw));
    chk({tag, ".WriteRegW"}, 32'(bus.WriteRegW), 32'(rd));
    chk({tag, ".WriteDataW"}, bus.WriteDataW, d);
  endtask

  task automatic chk_fwd(string tag, logic v, logic [4:0] rd, logic [31:0] d);
    chk({tag, ".FwdValid"}, 32'(bus.FwdValid), 32'(v));
    chk({tag, ".FwdReg"}, 32'(bus.FwdReg), 32'(rd));
    chk({tag, ".FwdData"}, bus.FwdData, d);
  endtask

  initial begin
    logic [31:0] cnt;

    vecs[0]  = mk(1, 1, 5'd8,  2'd0, 32'h1234_5678, LT_WORD, 2'd0, 1, 32'h1234_5678, 32'h1234_5678);
    vecs[1]  = mk(1, 1, 5'd9,  2'd1, 32'hA0A0_A0A0, LT_LB,   2'd3, 1, 32'hFFFF_FF80, MemWord);
    vecs[2]  = mk(1, 1, 5'd10, 2'd1, 32'hA0A0_A0A0, LT_LBU,  2'd2, 1, 32'h0000_00FF, MemWord);
    vecs[3]  = mk(1, 1, 5'd11, 2'd1, 32'hA0A0_A0A0, LT_LH,   2'd2, 1, 32'hFFFF_80FF, MemWord);
    vecs[4]  = mk(1, 1, 5'd12, 2'd1, 32'hA0A0_A0A0, LT_LHU,  2'd0, 1, 32'h0000_7F01, MemWord);
    vecs[5]  = mk(1, 1, 5'd13, 2'd1, 32'hA0A0_A0A0, LT_LH,   2'd3, 1, 32'hFFFF_80FF, MemWord);
    vecs[6]  = mk(1, 1, 5'd0,  2'd0, 32'hDEAD_BEEF, LT_WORD, 2'd0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vecs[7]  = mk(1, 1, 5'd31, 2'd2, 32'hA0A0_A0A0, LT_WORD, 2'd0, 1, LinkWord, LinkWord);
    vecs[8]  = mk(1, 1, 5'd7,  2'd3, 32'hA0A0_A0A0, LT_LB,   2'd1, 1, HiloWord, HiloWord);
    vecs[9]  = mk(1, 1, 5'd14, 2'd1, 32'hA0A0_A0A0, LT_WORD, 2'd1, 1, MemWord, MemWord);
    vecs[10] = mk(1, 1, 5'd15, 2'd0, 32'h0000_00F0, LT_LB,   2'd0, 1, 32'h0000_00F0, 32'h0000_00F0);
    vecs[11] = mk(1, 0, 5'd17, 2'd1, 32'hA0A0_A0A0, 3'd6,    2'd3, 0, MemWord, MemWord);
    vecs[12] = mk(0, 1, 5'd16, 2'd0, 32'h5555_5555, LT_WORD, 2'd0, 0, 32'h5555_5555, 32'h5555_5555);

    Reset      = 1'b1;
    bus.StallW = 1'b0;
    bus.FlushW = 1'b0;
    drive(1, 1, 5'd3, 2'd0, 32'h7777_7777, LT_WORD, 2'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_w("reset", 0, 0, 5'd0, 32'h0);
    chk_fwd("reset", 0, 5'd0, 32'h0);
    chk("reset.RetireCount", bus.RetireCount, 32'h0);
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].rd, vecs[i].sel, vecs[i].s0, vecs[i].lt,
            vecs[i].off);
      @(posedge Clk);
      @(negedge Clk);
      chk_w($sformatf("vec%0d", i), vecs[i].v, vecs[i].erw, vecs[i].rd, exp_data(vecs[i]));
      if (i == 0) chk_fwd("vec0", 0, 5'd0, 32'h0);
      else chk_fwd($sformatf("vec%0d", i), vecs[i-1].erw, vecs[i-1].rd, exp_data(vecs[i-1]));
    end
    chk("table.RetireCount", bus.RetireCount, 32'd12);

    // Stall for three edges while the M bundle keeps changing.
    drive(1, 1, 5'd5, 2'd0, 32'h1111_1111, LT_WORD, 2'd0);
    @(posedge Clk);
    @(negedge Clk);
    cnt = 32'd13;
    chk("pre_stall.RetireCount", bus.RetireCount, cnt);
    bus.StallW = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 5'(20 + k), 2'd0, 32'h3333_0000 + 32'(k), LT_WORD, 2'd0);
      @(posedge Clk);
      @(negedge Clk);
      chk_w($sformatf("stall%0d", k), 1, 1, 5'd5, 32'h1111_1111);
      chk_fwd($sformatf("stall%0d", k), vecs[12].erw, vecs[12].rd, exp_data(vecs[12]));
      chk($sformatf("stall%0d.RetireCount", k), bus.RetireCount, cnt);
    end
    bus.StallW = 1'b0;
    drive(1, 1, 5'd6, 2'd0, 32'h2222_2222, LT_WORD, 2'd0);
    @(posedge Clk);
    @(negedge Clk);
    chk_w("unstall", 1, 1, 5'd6, 32'h2222_2222);
    chk_fwd("unstall", 1, 5'd5, 32'h1111_1111);
    chk("unstall.RetireCount", bus.RetireCount, cnt + 1);

    // Flush together with stall: flush wins, nothing retires.
    bus.FlushW = 1'b1;
    bus.StallW = 1'b1;
    drive(1, 1, 5'd9, 2'd0, 32'h4444_4444, LT_WORD, 2'd0);
    @(posedge Clk);
    @(negedge Clk);
    chk_w("flush", 0, 0, 5'd0, 32'h0);
    chk("flush.RetireCount", bus.RetireCount, cnt + 1);
    bus.FlushW = 1'b0;
    bus.StallW = 1'b0;

    // Reset in the middle of back-to-back valid traffic.
    drive(1, 1, 5'd10, 2'd0, 32'h6666_0001, LT_WORD, 2'd0);
    @(posedge Clk);
    drive(1, 1, 5'd11, 2'd0, 32'h6666_0002, LT_WORD, 2'd0);
    @(posedge Clk);
    @(negedge Clk);
    chk_w("b2b", 1, 1, 5'd11, 32'h6666_0002);
    chk("b2b.RetireCount", bus.RetireCount, cnt + 3);
    Reset = 1'b1;
    drive(1, 1, 5'd12, 2'd0, 32'h6666_0003, LT_WORD, 2'd0);
    @(posedge Clk);
    @(negedge Clk);
    chk_w("midreset", 0, 0, 5'd0, 32'h0);
    chk_fwd("midreset", 0, 5'd0, 32'h0);
    chk("midreset.RetireCount", bus.RetireCount, 32'h0);
    Reset = 1'b0;

    // Counter wrap via a backdoor preload of the retire register.
    drive(0, 0, 5'd0, 2'd0, 32'h0, LT_WORD, 2'd0);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    drive(1, 1, 5'd1, 2'd0, 32'h0000_0001, LT_WORD, 2'd0);
    @(posedge Clk);
    @(negedge Clk);
    chk("wrap.RetireCount", bus.RetireCount, 32'h0);
    chk_w("wrap", 1, 1, 5'd1, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
